// File: rtl/uart_rx_sequencer.sv
// 16x-oversampling UART receiver: 8 data bits LSB first, optional parity, one stop bit.
// Delivers each byte over a valid/ready handshake with per-byte error flags and a sticky overrun.
module uart_rx_sequencer #(
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_tick,
    input  logic       serial_in,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       parity_error,
    output logic       framing_error,
    output logic       overrun,
    input  logic       clear_errors,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        sync_q1;
    logic        rxd;
    logic [3:0]  tick_cnt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        parity_pend;
    logic        tick_mid;
    logic        tick_last;
    logic        frame_done;
    logic        accept_frame;

    assign tick_mid     = baud_tick && (tick_cnt == 4'd6);
    assign tick_last    = baud_tick && (tick_cnt == 4'd15);
    assign frame_done   = (state == STOP) && tick_last;
    assign accept_frame = !rx_valid || rx_ready;

    // Line idles high, so the synchronizer resets to 1 to avoid a false start bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b1;
            rxd     <= 1'b1;
        end else begin
            sync_q1 <= serial_in;
            rxd     <= sync_q1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:       if (baud_tick && !rxd) state_next = START;
            START:      if (tick_mid) state_next = rxd ? IDLE : DATA;
            DATA:       if (tick_last && (bit_cnt == 3'd7)) state_next = PARITY_EN ? PARITY : STOP;
            PARITY:     if (tick_last) state_next = STOP;
            STOP:       if (tick_last) state_next = rxd ? IDLE : BREAK_WAIT;
            BREAK_WAIT: if (rxd) state_next = IDLE;
            default:    state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // Every state change restarts the tick count, so each phase measures from its own entry.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt    <= 4'd0;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            parity_pend <= 1'b0;
        end else begin
            if (state_next != state) begin
                tick_cnt <= 4'd0;
            end else if (baud_tick) begin
                tick_cnt <= tick_cnt + 4'd1;
            end

            if (state != DATA) begin
                bit_cnt <= 3'd0;
            end else if (tick_last) begin
                bit_cnt   <= bit_cnt + 3'd1;
                shift_reg <= {rxd, shift_reg[7:1]};
            end

            if ((state == PARITY) && tick_last) begin
                parity_pend <= (^shift_reg) ^ rxd ^ PARITY_ODD;
            end
        end
    end

    // A completed frame is only loaded when the output slot is free or being emptied this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data       <= 8'h00;
            rx_valid      <= 1'b0;
            parity_error  <= 1'b0;
            framing_error <= 1'b0;
            overrun       <= 1'b0;
        end else begin
            if (frame_done && accept_frame) begin
                rx_data       <= shift_reg;
                parity_error  <= PARITY_EN ? parity_pend : 1'b0;
                framing_error <= !rxd;
                rx_valid      <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            if (frame_done && !accept_frame) begin
                overrun <= 1'b1;
            end else if (clear_errors) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_sequencer.sv
// Bench for uart_rx_sequencer: frames are driven bit by bit, expectations are queued at send time
// and a negedge monitor pops and compares every byte the receiver hands over.
module tb_uart_rx_sequencer;

    localparam int  TICK_DIV   = 4;
    localparam int  BIT_CLKS   = 16 * TICK_DIV;
    localparam bit  PARITY_ODD = 1'b0;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_tick = 1'b0;
    logic       serial_in = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       parity_error;
    logic       framing_error;
    logic       overrun;
    logic       clear_errors = 1'b0;
    logic       busy;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t sb_q[$];
    int   checks_total  = 0;
    int   checks_passed = 0;

    uart_rx_sequencer #(
        .PARITY_EN (1'b1),
        .PARITY_ODD(PARITY_ODD)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .baud_tick    (baud_tick),
        .serial_in    (serial_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_ready     (rx_ready),
        .parity_error (parity_error),
        .framing_error(framing_error),
        .overrun      (overrun),
        .clear_errors (clear_errors),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (TICK_DIV - 1) @(posedge clk);
            #1 baud_tick = 1'b1;
            @(posedge clk);
            #1 baud_tick = 1'b0;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks_total++;
        if (actual === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic drive_bit(input logic v);
        serial_in = v;
        repeat (BIT_CLKS) @(posedge clk);
        #1;
    endtask

    // Drives start, data, parity and stop; the expected byte comes from the bits actually on the line.
    task automatic applyStimulus(input logic [7:0] data, input bit bad_parity, input logic stop_val,
                                 input bit expect_delivery);
        exp_t e;
        logic pbit;
        pbit   = (^data) ^ PARITY_ODD ^ bad_parity;
        e.data = data;
        e.pe   = ((^data) ^ pbit ^ PARITY_ODD) != 1'b0;
        e.fe   = (stop_val == 1'b0);
        if (expect_delivery) sb_q.push_back(e);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(data[i]);
        drive_bit(pbit);
        drive_bit(stop_val);
    endtask

    always @(negedge clk) begin
        if (reset_n && rx_valid && rx_ready) begin
            if (sb_q.size() == 0) begin
                checks_total++;
                $display("[TB] FAIL unexpected_byte: got 0x%0h, expected no delivery", rx_data);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checkOutput("rx_data", {24'h0, rx_data}, {24'h0, e.data});
                checkOutput("parity_error", {31'h0, parity_error}, {31'h0, e.pe});
                checkOutput("framing_error", {31'h0, framing_error}, {31'h0, e.fe});
            end
        end
    end

    initial begin
        repeat (80000) @(posedge clk);
        $display("[TB] FAIL watchdog: simulation exceeded cycle budget");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] d;
        logic       stop_v;
        int         wait_cnt;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rx_data", {24'h0, rx_data}, 32'h0);
        checkOutput("reset_rx_valid", {31'h0, rx_valid}, 32'h0);
        checkOutput("reset_flags", {29'h0, parity_error, framing_error, overrun}, 32'h0);
        checkOutput("reset_busy", {31'h0, busy}, 32'h0);
        reset_n = 1'b1;
        drive_bit(1'b1);

        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b1);
        drive_bit(1'b1);
        applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1);
        drive_bit(1'b1);

        // Stop bit low followed by a long break: receiver must wait for the line to recover.
        applyStimulus(8'h81, 1'b0, 1'b0, 1'b1);
        repeat (20) drive_bit(1'b0);
        checkOutput("break_busy_mid", {31'h0, busy}, 32'h1);
        repeat (20) drive_bit(1'b0);
        checkOutput("break_busy_end", {31'h0, busy}, 32'h1);
        drive_bit(1'b1);
        checkOutput("break_released", {31'h0, busy}, 32'h0);
        applyStimulus(8'h55, 1'b0, 1'b1, 1'b1);
        drive_bit(1'b1);

        // Short low pulse: start detected, then rejected at mid start bit.
        serial_in = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("glitch_start_busy", {31'h0, busy}, 32'h1);
        repeat (4) @(posedge clk);
        #1;
        drive_bit(1'b1);
        checkOutput("glitch_rejected", {31'h0, busy}, 32'h0);

        // Consumer stalls: second frame must be dropped and flagged.
        rx_ready = 1'b0;
        applyStimulus(8'h11, 1'b0, 1'b1, 1'b1);
        drive_bit(1'b1);
        applyStimulus(8'h22, 1'b0, 1'b1, 1'b0);
        drive_bit(1'b1);
        checkOutput("ovr_valid_held", {31'h0, rx_valid}, 32'h1);
        checkOutput("ovr_data_held", {24'h0, rx_data}, 32'h11);
        checkOutput("ovr_set", {31'h0, overrun}, 32'h1);
        clear_errors = 1'b1;
        @(posedge clk);
        #1 clear_errors = 1'b0;
        checkOutput("ovr_cleared", {31'h0, overrun}, 32'h0);
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("ovr_drained", {31'h0, rx_valid}, 32'h0);

        // Reset in the middle of data bit 4 abandons the frame.
        d = 8'hC3;
        serial_in = 1'b0;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        serial_in = d[4];
        repeat (BIT_CLKS / 2) @(posedge clk);
        #1 reset_n = 1'b0;
        #1;
        checkOutput("midreset_busy", {31'h0, busy}, 32'h0);
        checkOutput("midreset_outputs", {21'h0, rx_data, rx_valid, parity_error, framing_error}, 32'h0);
        serial_in = 1'b1;
        repeat (4) @(posedge clk);
        #1 reset_n = 1'b1;
        drive_bit(1'b1);
        applyStimulus(8'hF0, 1'b0, 1'b1, 1'b1);
        drive_bit(1'b1);

        // Randomized frames with occasional parity corruption and short breaks.
        for (int n = 0; n < 20; n++) begin
            d      = 8'($urandom_range(0, 255));
            stop_v = ($urandom_range(0, 5) != 0);
            applyStimulus(d, ($urandom_range(0, 3) == 0), stop_v, 1'b1);
            if (!stop_v) repeat ($urandom_range(0, 3)) drive_bit(1'b0);
            drive_bit(1'b1);
        end

        wait_cnt = 0;
        while (sb_q.size() != 0 && wait_cnt < 2 * BIT_CLKS) begin
            @(posedge clk);
            wait_cnt++;
        end
        checkOutput("scoreboard_drained", sb_q.size(), 32'h0);
        checkOutput("final_overrun", {31'h0, overrun}, 32'h0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
